mux_nway_rr: RTL
================

Name: mux_nway_rr

Overview:
- Parametrised successor to the combinational 16-bit 2:1 / 8-way muxes: N input channels of WIDTH bits, merged onto one registered output channel.
- Each side uses a valid/ready handshake.
- Selection is arbitrated, either by fixed priority or by round-robin, instead of an external select line.
- Used wherever several producers (ALU result, memory read, I/O) share one consumer bus.

Parameters:
- WIDTH, 16, data width per channel (≥1).
- N, 8, number of input channels (≥2; need not be a power of two).
- SELW, $clog2(N), width of the channel index (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- in_valid  input  N  channel i has data.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  one-hot or zero; channel i's word is taken this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered word.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0. in_ready is all-zero while reset is high.
- Load enable: load = !out_valid | out_ready.
- Grant, combinational:
  - If load=0, the grant is all-zero.
  - Otherwise, mode=0 grants the lowest i with in_valid[i].
  - Otherwise, mode=1 grants the first i with in_valid[i], searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap mod N, correct for non-power-of-two N).
  - in_ready = grant.
  - in_ready must not depend on in_ready; it may depend on out_ready.
- Transfer on an input: in_valid[i] & in_ready[i] at a rising edge.
- On any grant: out_data <= in_data[i], out_sel <= i, out_valid <= 1.
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 word/cycle when out_ready is held high.
- With load=1 and no valid input: out_valid <= 0 (pops the drained word). out_data/out_sel keep their last values.
- Stall: while out_valid & !out_ready, out_data/out_sel/out_valid are held stable and in_ready=0.
- Round-robin pointer:
  - On a grant to i (either mode), ptr <= (i==N-1) ? 0 : i+1.
  - ptr is unchanged when there is no grant.
  - ptr is updated in mode 0 too, so switching to mode 1 resumes after the last winner.
- Mode change takes effect in the same cycle's grant computation (mode is sampled combinationally); there is no internal mode state.
- Simultaneous drain and load in one cycle is legal and yields back-to-back words with no bubble.
- Producers must hold in_data stable while in_valid is high and not yet granted. The block does not check this.
- Reset asserted mid-transfer: the word in the output register is discarded and no grant occurs.

Decomposition:
- Shared package mux_pkg holds MODE_FIXED=1'b0 and MODE_RR=1'b1, plus a clog2 helper function if the toolchain lacks $clog2.
- One sub-module, rr_arbiter #(N):
  - inputs req[N], ptr[SELW], mode, en;
  - outputs grant[N] (one-hot or zero) and grant_idx[SELW].
  - Implement via the double-width request vector rotate/mask technique.
- The top level holds the output register, ptr, and the data mux. The data mux is an AND-OR over the one-hot grant, consistent with the gate-level mux family.

Test Plan:
- Reset: hold reset with all in_valid=1 → in_ready=0, out_valid=0, out_data=0, out_sel=0. After release, the first grant goes to channel 0 in both modes.
- Fixed priority, all N=8 valid, out_ready=1, mode=0 → out_sel = 0,0,0,… every cycle. Drop in_valid[0] → out_sel=1 on the next output.
- Round-robin, all valid with in_data[i]=16'h1000+i, mode=1, out_ready=1 → out_sel sequence 0,1,…,7,0 (wrap). out_data matches; out_valid stays continuously high.
- Backpressure: out_ready=0 for 3 cycles after a word from channel 2 (out_data=16'h1002) → out_data/out_sel stable and in_ready=0 for all 3 cycles. The following cycle accepts channel 3 with no bubble.
- Non-power-of-two: N=5, mode=1, only channels 4 and 0 valid → out_sel alternates 4,0,4,0. ptr wraps 4→0 and never reaches 5.
- Mode switch and mid-operation reset: in mode 0, channel 5 wins, then switch to mode 1 with all valid → the next winner is 6. Assert reset asynchronously while out_valid=1 → out_valid falls immediately, with no clock edge needed.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the arbitrated N-way mux family.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Fixed-priority / round-robin arbiter using the double-width request subtract-and-mask trick.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            mode,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  logic [SELW-1:0] w_start;
  logic [2*N-1:0]  w_req2;
  logic [2*N-1:0]  w_base;
  logic [2*N-1:0]  w_win2;

  // Subtracting the start one-hot borrows through to the first request at or above it, wrapping via the upper copy.
  always_comb begin
    w_start = '0;
    if ((mode == MODE_RR) && (int'(ptr) < N)) begin
      w_start = ptr;
    end else begin
      w_start = '0;
    end
    w_req2 = {req, req};
    w_base = {{(2*N-1){1'b0}}, 1'b1} << w_start;
    w_win2 = w_req2 & ~(w_req2 - w_base);
    if (en) begin
      grant = w_win2[N-1:0] | w_win2[2*N-1:N];
    end else begin
      grant = '0;
    end
  end

  // One-hot to index encoder.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      grant_idx = grant_idx | (SELW'(i) & {SELW{grant[i]}});
    end
  end

endmodule

// File: rtl/mux_nway_rr.sv
// N-channel valid/ready merge onto one registered output, with fixed-priority or round-robin selection.
module mux_nway_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N     = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [N-1:0]     in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_sel,
  input  logic             out_ready
);

  logic             w_load;
  logic             w_en;
  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_grant_idx;
  logic [WIDTH-1:0] w_mux;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_sel;
  logic [SELW-1:0]  r_ptr;

  assign w_load = ~r_out_valid | out_ready;
  assign w_en   = w_load & ~reset;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (r_ptr),
    .mode      (mode),
    .en        (w_en),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign in_ready = w_grant;

  // AND-OR data select over the one-hot grant.
  always_comb begin
    w_mux = '0;
    for (int i = 0; i < N; i++) begin
      w_mux = w_mux | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
    end
  end

  // Output register and round-robin pointer; a load with no grant drains the word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (|w_grant) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux;
        r_out_sel   <= w_grant_idx;
        r_ptr       <= (w_grant_idx == SELW'(N-1)) ? '0 : w_grant_idx + SELW'(1);
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
